// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the byte-addressable data memory.
//   SZ_*          request size encodings (byte, half, word, reserved)
//   clr_state_e   reset-clear sequencer states
//   lane_mask()   byte-lane write mask for a given size and addr[1:0]
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } clr_state_e;

    // Lanes touched by a store; misaligned halves/words are rejected upstream.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts the addressed byte/half from a memory word,
// moves it to bit 0 and sign- or zero-extends it. Purely combinational.
//   word_i     raw 32-bit memory word
//   lane_i     byte lane (addr[1:0])
//   size_i     access size (SZ_B/SZ_H/SZ_W)
//   unsigned_i 1 = zero-extend
//   data_c_o   extended 32-bit load result
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_c_o
);

    logic [31:0] shifted;

    // Shift selected lane down to bit 0, then extend by size.
    always_comb begin
        shifted  = word_i >> {lane_i, 3'b000};
        data_c_o = '0;
        case (size_i)
            SZ_B: data_c_o = unsigned_i ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: data_c_o = unsigned_i ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            SZ_W: data_c_o = word_i;
            default: data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable RV32I data memory with valid/ready request
// and one-cycle registered response. Optional reset-clear sequencer enabled by
// the DMEM_RST_CLEAR_EN macro.
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o, req_we_i, req_size_i, req_unsigned_i,
//   req_addr_i, req_wdata_i        request channel
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   response (no backpressure)
//   busy_o                          clear sequence in progress
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             accept;
    logic             out_of_range;
    logic             misalign;
    logic             fault;
    logic [31:0]      st_data;
    logic [31:0]      ld_data;

    logic             clr_we;
    logic [IDX_W-1:0] clr_ptr;
    logic             ready_s;
    logic             busy_s;

    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;

    assign idx          = req_addr_i[IDX_W+1:2];
    assign lane         = req_addr_i[1:0];
    assign accept       = req_valid_i & ready_s;
    assign out_of_range = (req_addr_i >> (IDX_W + 2)) != '0;
    assign fault        = misalign | out_of_range;

    // Alignment and reserved-size faults.
    always_comb begin
        misalign = 1'b0;
        case (req_size_i)
            SZ_H:    misalign = lane[0];
            SZ_W:    misalign = |lane;
            SZ_RSV:  misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    // Replicate store data across lanes so the byte enables pick the right copy.
    always_comb begin
        st_data = req_wdata_i;
        case (req_size_i)
            SZ_B:    st_data = {4{req_wdata_i[7:0]}};
            SZ_H:    st_data = {2{req_wdata_i[15:0]}};
            default: st_data = req_wdata_i;
        endcase
    end

`ifdef DMEM_RST_CLEAR_EN
    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Zero one word per cycle, then open the request port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ptr_d = '0;
            end
        endcase
    end

    assign clr_ptr = ptr_q;
    assign ready_s = (state_q == ST_IDLE);
    assign busy_s  = (state_q == ST_CLEAR);
`else
    logic ready_q;

    // Ready rises at the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign clr_we  = 1'b0;
    assign clr_ptr = '0;
    assign ready_s = ready_q;
    assign busy_s  = 1'b0;
`endif

    // Single write port shared by clear sequencer and stores (never concurrent).
    always_comb begin
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_data = st_data;
        if (clr_we) begin
            wr_idx  = clr_ptr;
            wr_be   = 4'b1111;
            wr_data = '0;
        end else if (accept && req_we_i && !fault) begin
            wr_be = lane_mask(req_size_i, lane);
        end
    end

    // Byte-write array; no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    dmem_load_align u_load_align (
        .word_i     (mem_q[idx]),
        .lane_i     (lane),
        .size_i     (req_size_i),
        .unsigned_i (req_unsigned_i),
        .data_c_o   (ld_data)
    );

    // Response payload: data only for good loads, zero otherwise.
    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept & fault;
        rsp_rdata_d = '0;
        if (accept && !fault && !req_we_i) begin
            rsp_rdata_d = ld_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = ready_s;
    assign busy_o      = busy_s;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed stimulus with a response scoreboard for
// data_mem_ctrl (DEPTH_WORDS=16). Adapts its clear checks to DMEM_RST_CLEAR_EN.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [1:0]        req_size_i = 2'b00;
    logic              req_unsigned_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [31:0]       req_wdata_i = '0;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              busy_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tag     = 0;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request at the falling edge; it is accepted at the next rising edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        req_valid_i = 1'b0;
        while (req_ready_o !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (req_ready_o !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready_o=%b required 1", req_ready_o);
            return;
        end
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        e.rdata = er;
        e.err   = ee;
        e.id    = tag;
        q.push_back(e);
        tag++;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Count cycles with busy high from reset release; ready must stay low.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            check({name, "_ready_low"}, 32'(req_ready_o), 32'd0);
            n++;
            @(posedge clk);
            #2;
        end
        check({name, "_cycles"}, 32'(n), 32'(DEPTH));
        check({name, "_ready_after"}, 32'(req_ready_o), 32'd1);
    endtask

    // Monitor: every response must match the oldest expectation, one cycle after accept.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid_o === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_rsp: rsp_valid_o=1 required 0");
                end else begin
                    e = q.pop_front();
                    check($sformatf("rsp%0d_rdata", e.id), rsp_rdata_o, e.rdata);
                    check($sformatf("rsp%0d_err", e.id), 32'(rsp_err_o), 32'(e.err));
                end
            end else begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp%0d_missing: rsp_valid_o=%b required 1", e.id, rsp_valid_o);
                end
                check("idle_rsp_zero", {rsp_rdata_o[31:1], rsp_rdata_o[0] | rsp_err_o}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rsp_rdata", rsp_rdata_o, 32'd0);
        check("reset_rsp_err", 32'(rsp_err_o), 32'd0);
        check("reset_ready", 32'(req_ready_o), 32'd0);
`ifdef DMEM_RST_CLEAR_EN
        check("reset_busy", 32'(busy_o), 32'd1);
`else
        check("reset_busy", 32'(busy_o), 32'd0);
`endif

        @(posedge clk);
        #2;
        rst_i = 1'b1;
`ifdef DMEM_RST_CLEAR_EN
        wait_clear("clear");
        issue(1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);
`else
        @(posedge clk);
        #2;
        check("noclr_ready", 32'(req_ready_o), 32'd1);
        check("noclr_busy", 32'(busy_o), 32'd0);
`endif

        // Byte store and sign/zero extension
        issue(1'b1, SZ_W, 1'b0, 32'h08, 32'h1122_3344, 32'h0, 1'b0);
        issue(1'b1, SZ_B, 1'b0, 32'h09, 32'hABCD_12F0, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 32'h1122_F044, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h09, 32'h0, 32'hFFFF_FFF0, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h09, 32'h0, 32'h0000_00F0, 1'b0);
        issue(1'b1, SZ_B, 1'b0, 32'h0B, 32'h0000_007F, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 32'h7F22_F044, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h0B, 32'h0, 32'h0000_007F, 1'b0);
        idle();

        // Half-word store and extension
        issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hAABB_CCDD, 32'h0, 1'b0);
        issue(1'b1, SZ_H, 1'b0, 32'h12, 32'h5555_8001, 32'h0, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0);
        issue(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8001_CCDD, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFF_CCDD, 1'b0);
        idle();
        idle();

        // Misalignment, range and reserved size
        issue(1'b0, SZ_W, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h00, 32'h5566_7788, 32'h0, 1'b0);
        issue(1'b1, SZ_H, 1'b0, 32'h03, 32'h0000_1234, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'h5566_7788, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b0, SZ_RSV, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_RSV, 1'b0, 32'h00, 32'h0000_0000, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'h5566_7788, 1'b0);
        idle();

        // Back-to-back store then load of the same word
        issue(1'b1, SZ_W, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset right after an accepted load clears the response immediately
        @(posedge clk);
        #2;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midreset_rsp_rdata", rsp_rdata_o, 32'd0);
        check("midreset_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
`ifdef DMEM_RST_CLEAR_EN
        repeat (5) @(posedge clk);
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        wait_clear("reclear");
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
`else
        @(posedge clk);
        #2;
        check("noclr_busy_after", 32'(busy_o), 32'd0);
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
`endif
        idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
